mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus writeback stage of the 5-stage core, directly downstream of the memory stage.
- Captures the memory-stage results (load word, ALU result, PC+4, rd, writeback controls) on each clock.
- Aligns and sign/zero-extends load data, selects the writeback value, and drives the register-file write port and the forwarding path.
- Handles stall, flush, x0 suppression and misaligned-load detection.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RESET_PC4, 32'h0000_0004, reset value of the registered PC+4 field.

Ports:
- i_clk  in  1  core clock, rising edge
- i_reset_n  in  1  asynchronous active-low reset
- i_valid  in  1  memory-stage slot holds a real instruction
- i_readData  in  32  word-aligned data word from data memory
- i_aluResult  in  32  ALU result, also the load address
- i_pcPlus4  in  32  PC+4 of the instruction (JAL/JALR link value)
- i_rd  in  5  destination register index
- i_funct3  in  3  load width/sign field
- i_ctrlWB  in  3  [0]=regWrite, [2:1]=wbSel (00 ALU, 01 MEM, 10 PC4, 11 reserved→ALU)
- i_stall  in  1  hold the current WB contents
- i_flush  in  1  insert a bubble
- o_valid  out  1  WB slot valid
- o_regWrite  out  1  register-file write enable
- o_rd  out  5  register-file write index
- o_wrData  out  32  register-file write data, also the forwarding value
- o_misaligned  out  1  misaligned load retired this cycle (1-cycle pulse per instruction)

Behaviour:
- All state is registered on the rising edge of i_clk and cleared asynchronously when i_reset_n=0.
- Reset values: valid=0, rd=0, ctrl=0, funct3=0, data fields=0, pc4=RESET_PC4. Resulting outputs: o_valid=0, o_regWrite=0, o_rd=0, o_wrData=0, o_misaligned=0.
- Latency: 1 cycle from MEM inputs to WB outputs. o_wrData is combinational from the registered fields only, with no input-to-output combinational path.
- Per-edge priority: flush > stall > load.
  - flush: valid←0 and ctrl←0; data fields are don't-care.
  - stall (no flush): every register holds.
  - otherwise: all fields load from the inputs; valid←i_valid.
- Load alignment, using registered addr[1:0] and funct3:
  - LB 000 / LBU 100: select byte lane addr[1:0], sign- or zero-extend.
  - LH 001 / LHU 101: select halfword lane addr[1], sign- or zero-extend.
  - LW 010 and unused codes 011/110/111: full word.
- Misaligned load: wbSel=MEM and either (LH/LHU with addr[0]=1) or (LW with addr[1:0]≠0). Result: o_misaligned=valid; o_regWrite forced 0.
- Writeback select: ALU→aluResult, MEM→aligned load data, PC4→pc4, reserved→aluResult.
- Write enable: o_regWrite = valid & regWrite & (rd≠0) & ~misaligned.
- o_rd is driven from the register regardless of enable.
- Stalled slot: outputs stay constant; the register-file write repeats harmlessly with identical data.
- Reset asserted mid-operation clears all state immediately, with no partial write.

Optional Feature:
- Macro: MEM_WB_INSTRET_EN.
- Defined:
  - Adds a 64-bit retired-instruction counter with output o_instret[63:0].
  - Increments by 1 on each rising edge where valid=1, ~i_stall and not misaligned; a stalled slot counts once.
  - Resets to 0 and wraps from 2^64-1 to 0.
- Undefined: the port and the counter are absent.

Decomposition:
- Package mem_wb_pkg:
  - wbsel_e enum (WB_ALU, WB_MEM, WB_PC4, WB_RSVD).
  - Load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
  - ctrlWB bit-index localparams.
- Sub-module wb_load_align: purely combinational; inputs word, addr[1:0], funct3; outputs aligned data and the misaligned flag.

Test Plan:
- Reset: hold i_reset_n=0, then release.
  → all outputs 0; o_valid=0 with no clock edge needed.
- LB, readData=32'h80FF_7F01, aluResult=32'h0000_1003, rd=5, ctrlWB=011.
  → one cycle later o_wrData=32'hFFFF_FF80, o_regWrite=1, o_rd=5.
- Same word with LBU, addr ...02.
  → o_wrData=32'h0000_00FF.
- LHU, addr ...02.
  → o_wrData=32'h0000_80FF.
- LW with aluResult=32'h0000_1002.
  → o_misaligned=1, o_regWrite=0.
- JAL: wbSel=PC4, pcPlus4=32'h0000_0104, rd=1.
  → o_wrData=32'h104.
- ALU op with rd=0.
  → o_regWrite=0.
- Stall 3 cycles while the inputs change.
  → outputs frozen.
- Assert flush and stall together.
  → bubble (o_valid=0, o_regWrite=0).
- With MEM_WB_INSTRET_EN: 4 valid instructions, one stalled 2 cycles, one flushed.
  → o_instret=3.

Source files
------------

// File: rtl/mem_wb_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | Module   : mem_wb_pkg                                              |
// | Purpose  : Shared types and constants for the MEM/WB stage         |
// | Revision : 1.0                                                     |
// +-------------------------------------------------------------------+
package mem_wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_PC4  = 2'b10,
    WB_RSVD = 2'b11
  } wbsel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam int CTRL_REGWRITE  = 0;
  localparam int CTRL_WBSEL_LSB = 1;
  localparam int CTRL_WBSEL_MSB = 2;

endpackage
`default_nettype wire

// File: rtl/mem_wb_stage_align.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | Module   : wb_load_align                                           |
// | Purpose  : Byte/halfword lane select, extension, misalign check    |
// | Revision : 1.0                                                     |
// +-------------------------------------------------------------------+
module wb_load_align
  import mem_wb_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data,
  output logic        o_misaligned
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[7:0];
    case (i_addr)
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      2'd3:    w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
    w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];

    o_data = i_word;
    case (i_funct3)
      F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  o_data = {24'd0, w_byte};
      F3_LH:   o_data = {{16{w_half[15]}}, w_half};
      F3_LHU:  o_data = {16'd0, w_half};
      default: o_data = i_word;
    endcase
  end

  // Unused funct3 codes are treated as full-word loads and never flag.
  assign o_misaligned = ((i_funct3 == F3_LH) || (i_funct3 == F3_LHU)) ? i_addr[0] :
                        (i_funct3 == F3_LW) ? (i_addr != 2'b00) : 1'b0;

endmodule
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | Module   : mem_wb_stage                                            |
// | Purpose  : MEM/WB pipeline register and writeback select.          |
// |            MEM_WB_INSTRET_EN adds a 64-bit retired counter.        |
// | Revision : 1.0                                                     |
// +-------------------------------------------------------------------+
module mem_wb_stage
  import mem_wb_pkg::*;
#(
  parameter int               XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC4 = 32'h0000_0004
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_valid,
  input  logic [XLEN-1:0] i_readData,
  input  logic [XLEN-1:0] i_aluResult,
  input  logic [XLEN-1:0] i_pcPlus4,
  input  logic [4:0]      i_rd,
  input  logic [2:0]      i_funct3,
  input  logic [2:0]      i_ctrlWB,
  input  logic            i_stall,
  input  logic            i_flush,
  output logic            o_valid,
  output logic            o_regWrite,
  output logic [4:0]      o_rd,
  output logic [XLEN-1:0] o_wrData,
  output logic            o_misaligned
`ifdef MEM_WB_INSTRET_EN
  ,
  output logic [63:0]     o_instret
`endif
);

  logic            r_valid;
  logic [XLEN-1:0] r_read_data;
  logic [XLEN-1:0] r_alu_result;
  logic [XLEN-1:0] r_pc4;
  logic [4:0]      r_rd;
  logic [2:0]      r_funct3;
  logic [2:0]      r_ctrl;

  logic [XLEN-1:0] w_load_data;
  logic            w_align_mis;
  logic            w_load_mis;
  wbsel_e          w_wbsel;

  // Flush only needs to kill valid and the controls; data fields are left alone.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_valid      <= 1'b0;
      r_read_data  <= '0;
      r_alu_result <= '0;
      r_pc4        <= RESET_PC4;
      r_rd         <= '0;
      r_funct3     <= '0;
      r_ctrl       <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (!i_stall) begin
      r_valid      <= i_valid;
      r_read_data  <= i_readData;
      r_alu_result <= i_aluResult;
      r_pc4        <= i_pcPlus4;
      r_rd         <= i_rd;
      r_funct3     <= i_funct3;
      r_ctrl       <= i_ctrlWB;
    end
  end

  wb_load_align u_align (
    .i_word       (r_read_data),
    .i_addr       (r_alu_result[1:0]),
    .i_funct3     (r_funct3),
    .o_data       (w_load_data),
    .o_misaligned (w_align_mis)
  );

  assign w_wbsel    = wbsel_e'(r_ctrl[CTRL_WBSEL_MSB:CTRL_WBSEL_LSB]);
  assign w_load_mis = (w_wbsel == WB_MEM) && w_align_mis;

  always_comb begin
    o_wrData = r_alu_result;
    case (w_wbsel)
      WB_MEM:  o_wrData = w_load_data;
      WB_PC4:  o_wrData = r_pc4;
      default: o_wrData = r_alu_result;
    endcase
  end

  assign o_valid      = r_valid;
  assign o_rd         = r_rd;
  assign o_misaligned = r_valid && w_load_mis;
  assign o_regWrite   = r_valid && r_ctrl[CTRL_REGWRITE] && (r_rd != 5'd0) && !w_load_mis;

`ifdef MEM_WB_INSTRET_EN
  logic [63:0] r_instret;

  // Counting only on non-stalled edges makes a held slot retire exactly once.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_instret <= '0;
    end else if (r_valid && !i_stall && !w_load_mis) begin
      r_instret <= r_instret + 64'd1;
    end
  end

  assign o_instret = r_instret;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | Module   : tb_mem_wb_stage                                         |
// | Purpose  : Vector table, directed sequences and random model check |
// | Revision : 1.0                                                     |
// +-------------------------------------------------------------------+
module tb_mem_wb_stage;

  typedef struct {
    logic        valid;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [2:0]  ctrl;
  } slot_t;

  typedef struct {
    slot_t       ins;
    logic [31:0] e_wr;
    logic        e_rw;
    logic        e_mis;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] read_data;
  logic [31:0] alu_result;
  logic [31:0] pc_plus4;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [2:0]  ctrl_wb;
  logic        stall;
  logic        flush;
  logic        out_valid;
  logic        reg_write;
  logic [4:0]  out_rd;
  logic [31:0] wr_data;
  logic        misaligned;
`ifdef MEM_WB_INSTRET_EN
  logic [63:0] instret;
`endif

  int checks = 0;
  int errors = 0;

  slot_t       m;
  logic [63:0] m_cnt;
  vec_t        vecs[$];

  always #5 clk = ~clk;

  mem_wb_stage #(.XLEN(32), .RESET_PC4(32'h0000_0004)) dut (
    .i_clk        (clk),
    .i_reset_n    (reset_n),
    .i_valid      (in_valid),
    .i_readData   (read_data),
    .i_aluResult  (alu_result),
    .i_pcPlus4    (pc_plus4),
    .i_rd         (rd),
    .i_funct3     (funct3),
    .i_ctrlWB     (ctrl_wb),
    .i_stall      (stall),
    .i_flush      (flush),
    .o_valid      (out_valid),
    .o_regWrite   (reg_write),
    .o_rd         (out_rd),
    .o_wrData     (wr_data),
    .o_misaligned (misaligned)
`ifdef MEM_WB_INSTRET_EN
    ,
    .o_instret    (instret)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference load semantics written as plain shifts and masks.
  function automatic logic [31:0] ref_load(logic [31:0] w, logic [1:0] a, logic [2:0] f3);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * int'(a))) & 32'h0000_00FF;
    h = (w >> (16 * int'(a[1]))) & 32'h0000_FFFF;
    case (f3)
      3'd0:    return b[7]  ? (b | 32'hFFFF_FF00) : b;
      3'd4:    return b;
      3'd1:    return h[15] ? (h | 32'hFFFF_0000) : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic ref_mis(slot_t s);
    int a;
    a = int'(s.alu[1:0]);
    if (s.ctrl[2:1] != 2'b01) return 1'b0;
    if ((s.f3 == 3'd1 || s.f3 == 3'd5) && (a % 2 != 0)) return 1'b1;
    if (s.f3 == 3'd2 && a != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_wr(slot_t s);
    case (s.ctrl[2:1])
      2'b01:   return ref_load(s.rdata, s.alu[1:0], s.f3);
      2'b10:   return s.pc4;
      default: return s.alu;
    endcase
  endfunction

  function automatic vec_t mk(logic v, logic [31:0] rdat, logic [31:0] alu, logic [31:0] pc4,
                              logic [4:0] r, logic [2:0] f3, logic [2:0] c,
                              logic [31:0] ewr, logic erw, logic emis);
    vec_t t;
    t.ins   = '{valid: v, rdata: rdat, alu: alu, pc4: pc4, rd: r, f3: f3, ctrl: c};
    t.e_wr  = ewr;
    t.e_rw  = erw;
    t.e_mis = emis;
    return t;
  endfunction

  task automatic set_in(input slot_t s, input logic st, input logic fl);
    in_valid   = s.valid;
    read_data  = s.rdata;
    alu_result = s.alu;
    pc_plus4   = s.pc4;
    rd         = s.rd;
    funct3     = s.f3;
    ctrl_wb    = s.ctrl;
    stall      = st;
    flush      = fl;
  endtask

  task automatic model_reset();
    m     = '{valid: 1'b0, rdata: 32'd0, alu: 32'd0, pc4: 32'h4, rd: 5'd0, f3: 3'd0, ctrl: 3'd0};
    m_cnt = 64'd0;
  endtask

  // One clock edge: the model follows the flush > stall > load rule.
  task automatic step();
    @(posedge clk);
    if (m.valid && !stall && !ref_mis(m)) m_cnt = m_cnt + 64'd1;
    if (flush) begin
      m.valid = 1'b0;
      m.ctrl  = 3'd0;
    end else if (!stall) begin
      m = '{valid: in_valid, rdata: read_data, alu: alu_result, pc4: pc_plus4,
            rd: rd, f3: funct3, ctrl: ctrl_wb};
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_valid"}, {63'd0, out_valid}, {63'd0, m.valid});
    chk({tag, "_rw"}, {63'd0, reg_write},
        {63'd0, m.valid && m.ctrl[0] && (m.rd != 5'd0) && !ref_mis(m)});
    chk({tag, "_rd"}, {59'd0, out_rd}, {59'd0, m.rd});
    chk({tag, "_wr"}, {32'd0, wr_data}, {32'd0, ref_wr(m)});
    chk({tag, "_mis"}, {63'd0, misaligned}, {63'd0, m.valid && ref_mis(m)});
`ifdef MEM_WB_INSTRET_EN
    chk({tag, "_instret"}, instret, m_cnt);
`endif
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_rw"}, {63'd0, reg_write}, 64'd0);
    chk({tag, "_rd"}, {59'd0, out_rd}, 64'd0);
    chk({tag, "_wr"}, {32'd0, wr_data}, 64'd0);
    chk({tag, "_mis"}, {63'd0, misaligned}, 64'd0);
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    model_reset();
    #1;
    check_zero(tag);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    slot_t idle;
    slot_t lb;
    slot_t r;
    idle = '{valid: 1'b0, rdata: 32'd0, alu: 32'd0, pc4: 32'd0, rd: 5'd0, f3: 3'd0, ctrl: 3'd0};
    lb   = '{valid: 1'b1, rdata: 32'h80FF_7F01, alu: 32'h0000_1003, pc4: 32'h0,
             rd: 5'd5, f3: 3'b000, ctrl: 3'b011};

    vecs.push_back(mk(1, 32'h80FF_7F01, 32'h0000_1003, 32'h0, 5'd5, 3'b000, 3'b011, 32'hFFFF_FF80, 1, 0));
    vecs.push_back(mk(1, 32'h80FF_7F01, 32'h0000_1002, 32'h0, 5'd6, 3'b100, 3'b011, 32'h0000_00FF, 1, 0));
    vecs.push_back(mk(1, 32'h80FF_7F01, 32'h0000_1002, 32'h0, 5'd7, 3'b101, 3'b011, 32'h0000_80FF, 1, 0));
    vecs.push_back(mk(1, 32'h80FF_7F01, 32'h0000_1002, 32'h0, 5'd7, 3'b001, 3'b011, 32'hFFFF_80FF, 1, 0));
    vecs.push_back(mk(1, 32'h80FF_7F01, 32'h0000_1002, 32'h0, 5'd8, 3'b010, 3'b011, 32'h80FF_7F01, 0, 1));
    vecs.push_back(mk(1, 32'h1111_2222, 32'h0000_3000, 32'h0000_0104, 5'd1, 3'b000, 3'b101, 32'h0000_0104, 1, 0));
    vecs.push_back(mk(1, 32'h0, 32'h1234_5678, 32'h0, 5'd0, 3'b000, 3'b001, 32'h1234_5678, 0, 0));
    vecs.push_back(mk(1, 32'h5555_5555, 32'hDEAD_BEEF, 32'h0, 5'd9, 3'b000, 3'b111, 32'hDEAD_BEEF, 1, 0));
    vecs.push_back(mk(1, 32'h80FF_7F01, 32'h0000_1000, 32'h0, 5'd10, 3'b000, 3'b011, 32'h0000_0001, 1, 0));
    vecs.push_back(mk(1, 32'h80FF_7F01, 32'h0000_1000, 32'h0, 5'd11, 3'b010, 3'b011, 32'h80FF_7F01, 1, 0));
    vecs.push_back(mk(0, 32'h0, 32'h0000_00AA, 32'h0, 5'd3, 3'b000, 3'b001, 32'h0000_00AA, 0, 0));
    vecs.push_back(mk(1, 32'h80FF_7F01, 32'h0000_1001, 32'h0, 5'd12, 3'b001, 3'b011, 32'h0000_7F01, 0, 1));
    vecs.push_back(mk(1, 32'h80FF_7F01, 32'h0000_1003, 32'h0, 5'd13, 3'b011, 3'b011, 32'h80FF_7F01, 1, 0));

    // Reset held with junk inputs; outputs must be clear before any edge.
    reset_n = 1'b0;
    set_in(lb, 1'b0, 1'b0);
    model_reset();
    #2;
    check_zero("reset_noedge");
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_held");
    set_in(idle, 1'b0, 1'b0);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      set_in(vecs[i].ins, 1'b0, 1'b0);
      step();
      chk($sformatf("vec%0d_wr", i), {32'd0, wr_data}, {32'd0, vecs[i].e_wr});
      chk($sformatf("vec%0d_rw", i), {63'd0, reg_write}, {63'd0, vecs[i].e_rw});
      chk($sformatf("vec%0d_mis", i), {63'd0, misaligned}, {63'd0, vecs[i].e_mis});
      chk($sformatf("vec%0d_valid", i), {63'd0, out_valid}, {63'd0, vecs[i].ins.valid});
      chk($sformatf("vec%0d_rd", i), {59'd0, out_rd}, {59'd0, vecs[i].ins.rd});
    end

    // Stall for three cycles while the inputs keep changing.
    set_in(lb, 1'b0, 1'b0);
    step();
    for (int k = 0; k < 3; k++) begin
      r = '{valid: 1'b1, rdata: $urandom, alu: $urandom, pc4: $urandom,
            rd: 5'($urandom_range(31, 1)), f3: 3'($urandom_range(7, 0)), ctrl: 3'b101};
      set_in(r, 1'b1, 1'b0);
      step();
      chk($sformatf("stall%0d_wr", k), {32'd0, wr_data}, 64'hFFFF_FF80);
      chk($sformatf("stall%0d_rw", k), {63'd0, reg_write}, 64'd1);
      chk($sformatf("stall%0d_rd", k), {59'd0, out_rd}, 64'd5);
      chk($sformatf("stall%0d_valid", k), {63'd0, out_valid}, 64'd1);
    end

    // Flush wins over stall.
    set_in(lb, 1'b1, 1'b1);
    step();
    chk("flushstall_valid", {63'd0, out_valid}, 64'd0);
    chk("flushstall_rw", {63'd0, reg_write}, 64'd0);
    chk("flushstall_mis", {63'd0, misaligned}, 64'd0);

    // Reset asserted between edges clears a live slot immediately.
    set_in(lb, 1'b0, 1'b0);
    step();
    chk("preres_rw", {63'd0, reg_write}, 64'd1);
    do_reset("midreset");
    set_in(idle, 1'b0, 1'b0);

`ifdef MEM_WB_INSTRET_EN
    chk("instret_reset", instret, 64'd0);
    set_in(lb, 1'b0, 1'b0);       step();
    set_in(lb, 1'b0, 1'b0);       step();
    set_in(lb, 1'b1, 1'b0);       step();
    set_in(lb, 1'b1, 1'b0);       step();
    set_in(lb, 1'b0, 1'b0);       step();
    set_in(lb, 1'b0, 1'b1);       step();
    set_in(idle, 1'b0, 1'b0);     step();
    set_in(idle, 1'b0, 1'b0);     step();
    chk("instret_seq", instret, 64'd3);
    do_reset("instret_rst");
    set_in(idle, 1'b0, 1'b0);
`endif

    for (int n = 0; n < 400; n++) begin
      r = '{valid: ($urandom % 4) != 0, rdata: $urandom, alu: $urandom, pc4: $urandom,
            rd: 5'($urandom_range(31, 0)), f3: 3'($urandom_range(7, 0)),
            ctrl: 3'($urandom_range(7, 0))};
      set_in(r, ($urandom % 5) == 0, ($urandom % 8) == 0);
      step();
      check_model($sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
